hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised pipeline hazard controller for the in-order RISC-V core; it generalises the single-comparator stall controller. A shift-register scoreboard tracks in-flight destination registers through `STAGES` post-decode stages. From it the block produces per-operand forwarding selects, load-use stalls and a multi-cycle flush after taken branches, plus saturating stall and flush counters. It sits beside the ID stage, drives the IF write enable and the IF/ID and ID/EXE register controls, and takes `jumpEnable` from the branch unit.

## Interface
- `REG_AW`, 5, register address width
- `STAGES`, 3, tracked post-decode stages (entry 0 = EXE, 1 = MEM, 2 = WB); minimum 1
- `LOAD_LAT`, 1, index of the first stage whose result bus carries load data; 0 ≤ `LOAD_LAT` < `STAGES`
- `FLUSH_CYCLES`, 2, cycles `flush` stays high after a taken jump; minimum 1
- `CNT_W`, 16, performance counter width
- `SEL_W`, clog2(`STAGES`+1), width of the forwarding selects (derived)

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `id_valid` in 1: ID holds a real instruction
- `id_rs1`, `id_rs2` in `REG_AW`: source addresses
- `id_rs1_used`, `id_rs2_used` in 1: operand is actually read
- `id_rd` in `REG_AW`: destination address
- `id_rd_we` in 1: instruction writes `id_rd`
- `id_is_load` in 1: instruction is a load
- `jump_enable` in 1: taken branch/jump resolved in EXE this cycle
- `wrEnable` out 1: IF PC write enable
- `stall` out 1: hold the IF/ID register
- `idexe_bubble` out 1: load a NOP into the ID/EXE register
- `flush` out 1: clear the IF/ID register
- `fwd_sel_a`, `fwd_sel_b` out `SEL_W`: 0 = register file, k+1 = result bus of scoreboard stage k
- `stall_cnt`, `flush_cnt` out `CNT_W`: saturating event counters

## Operation
- Scoreboard entry fields: `{valid, rd, we, is_load}`. An entry counts as a writer only if `valid && we && rd != 0`.
- Every clock, entry k copies entry k-1.
- Entry 0 receives the ID instruction when `id_valid && !stall && !flush`. Otherwise it receives a bubble (`valid=0`).
- Operand match: the operand must be used and its address must be nonzero. Pick the youngest writer entry k (lowest k) with `rd == rs`.
  - No match: `fwd_sel = 0`.
  - Match, and entry k has `is_load && k < LOAD_LAT`: this is a load-use hazard and `fwd_sel = 0`.
  - Any other match: `fwd_sel = k+1`.
- `hazard = id_valid && (load-use on A || load-use on B)`.
- Flush counter `fcnt`:
  - Loaded with `FLUSH_CYCLES-1` when `jump_enable` is high.
  - Otherwise decrements toward 0.
  - A jump during an active flush reloads it.
- `flush = jump_enable || fcnt != 0`. Flush has priority over stall.
- `stall = hazard && !flush`; `idexe_bubble = stall || flush`; `wrEnable = !stall`. The PC still updates on a jump.
- Counters:
  - `stall_cnt` increments in every cycle with `stall=1`.
  - `flush_cnt` increments once per `jump_enable` pulse.
  - Both saturate at 2^`CNT_W`-1 with no wrap.

## Timing
- All outputs except the counters are combinational from the current scoreboard, `fcnt` and the ID/jump inputs, so they are valid in the same cycle.
- Scoreboard, `fcnt` and counters update on the rising edge of `clk`.
- Reset (asynchronous) clears all scoreboard entries to invalid and sets `fcnt=0` and both counters to 0.
- While in reset with inputs idle, outputs are: `wrEnable=1`, `stall=0`, `idexe_bubble=0`, `flush=0`, `fwd_sel_a/b=0`.
- Reset asserted mid-stall or mid-flush takes effect immediately, and the first cycle after release shows an empty pipeline.
- Load-use latency: with `LOAD_LAT=1` a dependent instruction is held exactly 1 cycle, then forwards from MEM (`fwd_sel=2`). A general load costs `LOAD_LAT` stall cycles.
- Flush lasts exactly `FLUSH_CYCLES` cycles from the `jump_enable` cycle, unless it is re-triggered.
- A simultaneous hazard and `jump_enable` produces flush only: `stall=0`, no stall count.
- rd=x0 never creates a hazard or forwarding. When both operands match the same entry, both selects are equal.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → outputs immediately take reset values and counters read 0. After release, `fwd_sel_a=0` even though x5 was in flight before reset.
- ALU chain forwarding: `addi x5` then `add x6,x5,x5` → `fwd_sel_a=fwd_sel_b=1`. With one independent instruction between them → `fwd_sel=2`; with two between → `fwd_sel=3`; with three between → `fwd_sel=0`.
- Youngest-wins: x7 written by entries 0 and 2, ID reads x7 → `fwd_sel_a=1`.
- Load-use: `lw x8` in EXE, ID reads x8 → one cycle with `stall=1`, `wrEnable=0`, `idexe_bubble=1`. The next cycle gives `fwd_sel=2` and `stall_cnt` equals 1. Repeat with `LOAD_LAT=2, STAGES=4` → 2 stall cycles.
- Flush: `jump_enable` pulse with `FLUSH_CYCLES=2` → `flush=1` for 2 cycles and entry 0 gets bubbles. A second pulse on the 2nd flush cycle extends the flush to 3 cycles total, and `flush_cnt` equals 2.
- Priority and saturation: load-use hazard coincident with `jump_enable` → `stall=0`, `flush=1`. With `CNT_W=4`, 20 stall cycles leave `stall_cnt=15`.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard controller: shift-register scoreboard of in-flight writers feeding
// forwarding selects, load-use stalls, multi-cycle post-jump flush and event counters.
module hazard_scoreboard #(
  parameter int REG_AW       = 5,
  parameter int STAGES       = 3,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16,
  parameter int SEL_W        = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rd_we,
  input  logic              id_is_load,
  input  logic              jump_enable,
  output logic              wrEnable,
  output logic              stall,
  output logic              idexe_bubble,
  output logic              flush,
  output logic [SEL_W-1:0]  fwd_sel_a,
  output logic [SEL_W-1:0]  fwd_sel_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              is_load;
  } entry_t;

  entry_t             sb_q [STAGES];
  entry_t             sb_d [STAGES];
  logic [STAGES-1:0]  writer;
  logic [FC_W-1:0]    fcnt_q, fcnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic [REG_AW-1:0]  op_rs   [2];
  logic               op_used [2];
  logic [SEL_W-1:0]   op_sel  [2];
  logic               op_lu   [2];
  logic               hazard;

  assign op_rs[0]   = id_rs1;
  assign op_rs[1]   = id_rs2;
  assign op_used[0] = id_rs1_used;
  assign op_used[1] = id_rs2_used;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      writer[k] = sb_q[k].valid && sb_q[k].we && (sb_q[k].rd != '0);
    end
  end

  // Scan oldest to youngest so the youngest matching writer overrides older ones.
  always_comb begin
    for (int op = 0; op < 2; op++) begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      op_sel[op] = '0;
      op_lu[op]  = 1'b0;
      for (int k = STAGES - 1; k >= 0; k--) begin
        if (op_used[op] && (op_rs[op] != '0) && writer[k] && (sb_q[k].rd == op_rs[op])) begin
          if (sb_q[k].is_load && (k < LOAD_LAT)) begin
            op_sel[op] = '0;
            op_lu[op]  = 1'b1;
          end else begin
            op_sel[op] = SEL_W'(k + 1);
            op_lu[op]  = 1'b0;
          end
        end
      end
    end
  end

  assign hazard       = id_valid && (op_lu[0] || op_lu[1]);
  assign flush        = jump_enable || (fcnt_q != '0);
  assign stall        = hazard && !flush;
  assign idexe_bubble = stall || flush;
  assign wrEnable     = !stall;
  assign fwd_sel_a    = op_sel[0];
  assign fwd_sel_b    = op_sel[1];
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

  always_comb begin
    sb_d[0] = '{valid:   id_valid && !stall && !flush,
                rd:      id_rd,
                we:      id_rd_we,
                is_load: id_is_load};
    for (int k = 1; k < STAGES; k++) begin
      sb_d[k] = sb_q[k-1];
    end

    if (jump_enable)         fcnt_d = FC_LOAD;
    else if (fcnt_q != '0)   fcnt_d = fcnt_q - FC_W'(1);
    else                     fcnt_d = '0;

    stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (jump_enable && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the scoreboard array is reset on purpose; stale valid bits would forward or stall wrongly.
      for (int k = 0; k < STAGES; k++) begin
        sb_q[k] <= '0;
      end
      fcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        sb_q[k] <= sb_d[k];
      end
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two configurations share one input stream and are
// compared every cycle against an issue-history reference model, plus directed checks.
module tb_hazard_scoreboard;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_rs1_used, id_rs2_used, id_rd_we, id_is_load, jump_enable;

  logic        a_wr, a_stall, a_bub, a_flush;
  logic [1:0]  a_sa, a_sb;
  logic [15:0] a_sc, a_fc;
  logic        b_wr, b_stall, b_bub, b_flush;
  logic [2:0]  b_sa, b_sb;
  logic [3:0]  b_sc, b_fc;

  hazard_scoreboard dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_rd_we(id_rd_we), .id_is_load(id_is_load), .jump_enable(jump_enable),
    .wrEnable(a_wr), .stall(a_stall), .idexe_bubble(a_bub), .flush(a_flush),
    .fwd_sel_a(a_sa), .fwd_sel_b(a_sb), .stall_cnt(a_sc), .flush_cnt(a_fc)
  );

  hazard_scoreboard #(.STAGES(4), .LOAD_LAT(2), .FLUSH_CYCLES(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_rd_we(id_rd_we), .id_is_load(id_is_load), .jump_enable(jump_enable),
    .wrEnable(b_wr), .stall(b_stall), .idexe_bubble(b_bub), .flush(b_flush),
    .fwd_sel_a(b_sa), .fwd_sel_b(b_sb), .stall_cnt(b_sc), .flush_cnt(b_fc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the log holds what each configuration issued into EXE per cycle;
  // an instruction issued k+1 cycles ago is the one sitting in stage k.
  typedef struct packed {
    bit       v;
    bit [4:0] rd;
    bit       we;
    bit       ld;
  } rec_t;

  int   m_stages [2] = '{3, 4};
  int   m_lat    [2] = '{1, 2};
  int   m_fc     [2] = '{2, 3};
  int   m_cmax   [2] = '{65535, 15};

  rec_t lg [2][4096];
  int   t;
  int   base [2];
  int   last_jump;
  int   scnt [2], fcn [2];
  bit   e_stall [2], e_flush [2];
  int   e_sa [2], e_sb [2];
  rec_t e_issue [2];
  bit   pending, p_jump;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      base[c] = t;
      scnt[c] = 0;
      fcn[c]  = 0;
    end
    last_jump = -1000;
    pending   = 1'b0;
  endtask

  task automatic find(input int c, input bit [4:0] rs, input bit used, output int sel, output bit lu);
    bit found = 1'b0;
    sel = 0;
    lu  = 1'b0;
    if (used && rs != 0) begin
      for (int k = 0; k < m_stages[c]; k++) begin
        int   idx = t - 1 - k;
        rec_t r;
        if (!found && idx >= base[c]) begin
          r = lg[c][idx];
          if (r.v && r.we && r.rd != 0 && r.rd == rs) begin
            found = 1'b1;
            if (r.ld && k < m_lat[c]) lu = 1'b1;
            else                      sel = k + 1;
          end
        end
      end
    end
  endtask

  task automatic evaluate_and_compare();
    for (int c = 0; c < 2; c++) begin
      int sa, sb;
      bit la, lb, fl, st;
      logic [31:0] o [8];
      string p;
      find(c, id_rs1, id_rs1_used, sa, la);
      find(c, id_rs2, id_rs2_used, sb, lb);
      fl = jump_enable || (t - last_jump < m_fc[c]);
      st = id_valid && (la || lb) && !fl;
      e_sa[c] = sa; e_sb[c] = sb; e_flush[c] = fl; e_stall[c] = st;
      e_issue[c] = '{v: id_valid && !st && !fl, rd: id_rd, we: id_rd_we, ld: id_is_load};
      if (c == 0) begin
        p = "A";
        o[0] = 32'(a_stall); o[1] = 32'(a_wr); o[2] = 32'(a_bub); o[3] = 32'(a_flush);
        o[4] = 32'(a_sa);    o[5] = 32'(a_sb); o[6] = 32'(a_sc);  o[7] = 32'(a_fc);
      end else begin
        p = "B";
        o[0] = 32'(b_stall); o[1] = 32'(b_wr); o[2] = 32'(b_bub); o[3] = 32'(b_flush);
        o[4] = 32'(b_sa);    o[5] = 32'(b_sb); o[6] = 32'(b_sc);  o[7] = 32'(b_fc);
      end
      check({p, ".stall"},        o[0], 32'(st));
      check({p, ".wrEnable"},     o[1], 32'(!st));
      check({p, ".idexe_bubble"}, o[2], 32'(st || fl));
      check({p, ".flush"},        o[3], 32'(fl));
      check({p, ".fwd_sel_a"},    o[4], 32'(sa));
      check({p, ".fwd_sel_b"},    o[5], 32'(sb));
      check({p, ".stall_cnt"},    o[6], 32'(scnt[c]));
      check({p, ".flush_cnt"},    o[7], 32'(fcn[c]));
    end
    pending = 1'b1;
    p_jump  = jump_enable;
  endtask

  task automatic commit();
    if (pending) begin
      for (int c = 0; c < 2; c++) begin
        lg[c][t] = e_issue[c];
        if (e_stall[c] && scnt[c] < m_cmax[c]) scnt[c]++;
        if (p_jump && fcn[c] < m_cmax[c])      fcn[c]++;
      end
      if (p_jump) last_jump = t;
      t++;
      pending = 1'b0;
    end
  endtask

  task automatic drive_idle();
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_rd_we = 1'b0; id_is_load = 1'b0;
    jump_enable = 1'b0;
  endtask

  // One clock: inputs change just after the rising edge, outputs are judged on the falling edge.
  task automatic step(input bit v, input bit [4:0] r1, input bit u1, input bit [4:0] r2,
                      input bit u2, input bit [4:0] rd, input bit we, input bit ld, input bit j);
    @(posedge clk);
    commit();
    #1;
    id_valid = v; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
    id_rd = rd; id_rd_we = we; id_is_load = ld; jump_enable = j;
    @(negedge clk);
    evaluate_and_compare();
  endtask

  task automatic alu(input bit [4:0] rd);
    step(1, 0, 1, 0, 0, rd, 1, 0, 0);
  endtask

  task automatic check_reset_outputs(input string p);
    check({p, "A.wrEnable"},     32'(a_wr),    32'd1);
    check({p, "A.stall"},        32'(a_stall), 32'd0);
    check({p, "A.idexe_bubble"}, 32'(a_bub),   32'd0);
    check({p, "A.flush"},        32'(a_flush), 32'd0);
    check({p, "A.fwd_sel_a"},    32'(a_sa),    32'd0);
    check({p, "A.fwd_sel_b"},    32'(a_sb),    32'd0);
    check({p, "A.stall_cnt"},    32'(a_sc),    32'd0);
    check({p, "A.flush_cnt"},    32'(a_fc),    32'd0);
    check({p, "B.flush"},        32'(b_flush), 32'd0);
    check({p, "B.stall_cnt"},    32'(b_sc),    32'd0);
  endtask

  initial begin
    t = 0;
    rst = 1'b1;
    drive_idle();
    model_reset();
    #3;
    check_reset_outputs("por.");
    #9 rst = 1'b0;

    // ALU chain: distance 1, 2, 3 and out of range.
    alu(5);
    step(1, 5, 1, 5, 1, 6, 1, 0, 0);
    check("chain1.A.fwd_sel_a", 32'(a_sa), 32'd1);
    check("chain1.A.fwd_sel_b", 32'(a_sb), 32'd1);
    alu(9); alu(10);
    step(1, 9, 1, 0, 1, 11, 1, 0, 0);
    check("chain2.A.fwd_sel_a", 32'(a_sa), 32'd2);
    alu(12); alu(13); alu(14);
    step(1, 12, 1, 0, 0, 19, 1, 0, 0);
    check("chain3.A.fwd_sel_a", 32'(a_sa), 32'd3);
    alu(15); alu(16); alu(17); alu(18);
    step(1, 15, 1, 0, 0, 19, 1, 0, 0);
    check("chain4.A.fwd_sel_a", 32'(a_sa), 32'd0);
    check("chain4.B.fwd_sel_a", 32'(b_sa), 32'd4);

    // Youngest writer wins.
    alu(7); alu(20); alu(7);
    step(1, 7, 1, 0, 0, 19, 1, 0, 0);
    check("young.A.fwd_sel_a", 32'(a_sa), 32'd1);

    // Load-use: one stall cycle on A, two on B.
    step(1, 0, 1, 0, 0, 8, 1, 1, 0);
    step(1, 8, 1, 0, 0, 21, 1, 0, 0);
    check("lu.A.stall",        32'(a_stall), 32'd1);
    check("lu.A.wrEnable",     32'(a_wr),    32'd0);
    check("lu.A.idexe_bubble", 32'(a_bub),   32'd1);
    step(1, 8, 1, 0, 0, 21, 1, 0, 0);
    check("lu2.A.stall",     32'(a_stall), 32'd0);
    check("lu2.A.fwd_sel_a", 32'(a_sa),    32'd2);
    check("lu2.A.stall_cnt", 32'(a_sc),    32'd1);
    check("lu2.B.stall",     32'(b_stall), 32'd1);
    step(1, 8, 1, 0, 0, 21, 1, 0, 0);
    check("lu3.B.stall",     32'(b_stall), 32'd0);
    check("lu3.B.fwd_sel_a", 32'(b_sa),    32'd3);
    check("lu3.B.stall_cnt", 32'(b_sc),    32'd2);

    // Flush length and re-trigger.
    step(1, 0, 0, 0, 0, 22, 1, 0, 1);
    check("fl0.A.flush", 32'(a_flush), 32'd1);
    check("fl0.A.wrEnable", 32'(a_wr), 32'd1);
    alu(22);
    check("fl1.A.flush", 32'(a_flush), 32'd1);
    alu(22);
    check("fl2.A.flush", 32'(a_flush), 32'd0);
    check("fl2.B.flush", 32'(b_flush), 32'd1);
    step(1, 0, 0, 0, 0, 23, 1, 0, 1);
    step(1, 0, 0, 0, 0, 23, 1, 0, 1);
    alu(23);
    check("flx.A.flush", 32'(a_flush), 32'd1);
    step(1, 23, 1, 0, 0, 25, 1, 0, 0);
    check("flx_end.A.flush",     32'(a_flush), 32'd0);
    check("flx_end.A.fwd_sel_a", 32'(a_sa),    32'd0);
    check("flx_end.A.flush_cnt", 32'(a_fc),    32'd3);

    // Load-use coincident with a jump: flush only.
    step(1, 0, 1, 0, 0, 24, 1, 1, 0);
    step(1, 24, 1, 0, 0, 26, 1, 0, 1);
    check("prio.A.stall", 32'(a_stall), 32'd0);
    check("prio.A.flush", 32'(a_flush), 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("prio.A.stall_cnt", 32'(a_sc), 32'd1);

    // Asynchronous reset in the middle of a stall.
    step(1, 0, 1, 0, 0, 5, 1, 1, 0);
    step(1, 5, 1, 0, 0, 27, 1, 0, 0);
    check("pre_rst.A.stall", 32'(a_stall), 32'd1);
    #2;
    rst = 1'b1;
    drive_idle();
    #1;
    check_reset_outputs("rst.");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    step(1, 5, 1, 5, 1, 27, 1, 0, 0);
    check("post_rst.A.fwd_sel_a", 32'(a_sa),    32'd0);
    check("post_rst.A.stall",     32'(a_stall), 32'd0);

    // Sustained load-use traffic drives the 4-bit counter of B into saturation.
    for (int i = 0; i < 45; i++) step(1, 8, 1, 0, 0, 8, 1, 1, 0);
    check("sat.B.stall_cnt", 32'(b_sc), 32'd15);

    // Random traffic on a small register set so that hits are frequent.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0,
           5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
